// File: rtl/result_capture_if.sv
// Streaming-result interface between the datapath output, the capture block and the result BRAM.
// The slave modport is the capture block's view; master is the driver/observer side.
interface result_capture_if #(
    parameter int DATA_W = 1024,
    parameter int ADDR_W = 6
);
    // Handshake: a beat transfers on every rising clk edge where valid_out is high.
    // There is no ready; the sink always accepts, and beats outside COLLECT are dropped.
    logic              start;
    logic [ADDR_W:0]   num_vec;
    logic              valid_out;
    logic [DATA_W-1:0] data_out;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   count;
    logic [31:0]       checksum;
    logic              overflow;
    logic [1:0]        dbg_state;

    modport slave (
        input  start, num_vec, valid_out, data_out,
        output mem_we, mem_addr, mem_din, busy, done, count, checksum, overflow, dbg_state
    );

    modport master (
        output start, num_vec, valid_out, data_out,
        input  mem_we, mem_addr, mem_din, busy, done, count, checksum, overflow, dbg_state
    );
endinterface

// File: rtl/result_capture.sv
// Captures a bounded run of result vectors into the result BRAM at consecutive addresses,
// tracking count, a lane-sum checksum and a sticky flag for beats that arrive after completion.
module result_capture #(
    parameter int DATA_W = 1024,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic             clk,
    input  logic             rst,
    result_capture_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_e;

    localparam int              LANES   = DATA_W / 32;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   target_q, target_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       checksum_q, checksum_d;
    logic              overflow_q, overflow_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [31:0]       lane_sum;
    logic [ADDR_W:0]   target_sel;
    logic [ADDR_W:0]   count_inc;

    always_comb begin
        lane_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_sum = lane_sum + bus.data_out[32*k +: 32];
        end
    end

    // Zero or out-of-range requests fall back to a full-depth run.
    assign target_sel = ((bus.num_vec == '0) || (bus.num_vec > DEPTH_C)) ? DEPTH_C : bus.num_vec;
    assign count_inc  = count_q + (ADDR_W+1)'(1);

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        count_d    = count_q;
        checksum_d = checksum_q;
        overflow_d = overflow_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;

        if (bus.start) begin
            state_d    = S_COLLECT;
            target_d   = target_sel;
            count_d    = '0;
            checksum_d = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                S_COLLECT: begin
                    if (bus.valid_out) begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = count_q[ADDR_W-1:0];
                        mem_din_d  = bus.data_out;
                        count_d    = count_inc;
                        checksum_d = checksum_q + lane_sum;
                        if (count_inc == target_q) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.valid_out) begin
                        overflow_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        busy_d = (state_d == S_COLLECT);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            target_q   <= '0;
            count_q    <= '0;
            checksum_q <= '0;
            overflow_q <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            count_q    <= count_d;
            checksum_q <= checksum_d;
            overflow_q <= overflow_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_din   = mem_din_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.count     = count_q;
    assign bus.checksum  = checksum_q;
    assign bus.overflow  = overflow_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_result_capture.sv
// Bench for result_capture: directed scenarios plus a randomized run, all checked against
// a run-level model of the capture (target, beats taken, lane sums, late-beat flag).
module tb_result_capture;
  localparam int DATA_W = 1024;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;
  localparam int LANES  = DATA_W / 32;
  typedef logic [ADDR_W+DATA_W-1:0] wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  result_capture_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
  result_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int passes = 0;
  wr_t exp_q[$];
  wr_t obs_q[$];

  bit                m_collect, m_done, m_ovf, m_we;
  int                m_target, m_count;
  logic [31:0]       m_sum;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_din;

  always @(negedge clk) if (bus.mem_we === 1'b1) obs_q.push_back({bus.mem_addr, bus.mem_din});

  function automatic logic [31:0] lane_total(input logic [DATA_W-1:0] d);
    logic [31:0] s = '0;
    for (int k = 0; k < LANES; k++) s += d[32*k +: 32];
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] rand_vec();
    logic [DATA_W-1:0] v;
    for (int k = 0; k < LANES; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    m_collect = 0; m_done = 0; m_ovf = 0; m_we = 0;
    m_target = 0; m_count = 0; m_sum = '0; m_addr = '0; m_din = '0;
  endtask

  // Drive one cycle of inputs, advance the model with the same inputs, end at negedge+1.
  task automatic step(input bit s, input int nv, input bit v, input logic [DATA_W-1:0] d);
    bus.start = s; bus.num_vec = (ADDR_W+1)'(nv); bus.valid_out = v; bus.data_out = d;
    @(posedge clk);
    if (s) begin
      m_collect = 1; m_done = 0; m_ovf = 0; m_we = 0; m_count = 0; m_sum = '0;
      m_target = (nv == 0 || nv > DEPTH) ? DEPTH : nv;
    end else if (m_collect) begin
      m_we = v;
      if (v) begin
        m_addr = ADDR_W'(m_count); m_din = d;
        exp_q.push_back({ADDR_W'(m_count), d});
        m_count++; m_sum += lane_total(d);
        if (m_count == m_target) begin m_collect = 0; m_done = 1; end
      end
    end else begin
      m_we = 0;
      if (m_done && v) m_ovf = 1;
    end
    @(negedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.num_vec = '0; bus.valid_out = 0; bus.data_out = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.mem_we !== 1'b0) $display("FAIL reset_mem_we: got %0b want 0", bus.mem_we); else passes++;
    checks++; if (bus.mem_addr !== '0) $display("FAIL reset_mem_addr: got %0h want 0", bus.mem_addr); else passes++;
    checks++; if (bus.mem_din !== '0) $display("FAIL reset_mem_din: got nonzero want 0"); else passes++;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL reset_busy_done: got %0b%0b want 00", bus.busy, bus.done); else passes++;
    checks++; if (bus.count !== '0) $display("FAIL reset_count: got %0d want 0", bus.count); else passes++;
    checks++; if (bus.checksum !== '0) $display("FAIL reset_checksum: got %0h want 0", bus.checksum); else passes++;
    checks++; if (bus.overflow !== 1'b0) $display("FAIL reset_overflow: got %0b want 0", bus.overflow); else passes++;
    rst = 0;
    model_reset();
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_basic();
    logic [DATA_W-1:0] ones;
    for (int k = 0; k < LANES; k++) ones[32*k +: 32] = 32'h1;
    exp_q.delete(); obs_q.delete();
    step(1, 4, 0, '0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, ones);
      checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== ADDR_W'(i)) $display("FAIL basic_write[%0d]: got we=%0b addr=%0d want we=1 addr=%0d", i, bus.mem_we, bus.mem_addr, i); else passes++;
      checks++; if (bus.done !== (i == 3)) $display("FAIL basic_done[%0d]: got %0b want %0b", i, bus.done, (i == 3)); else passes++;
    end
    step(0, 0, 0, '0);
    checks++; if (bus.mem_we !== 1'b0) $display("FAIL basic_we_after: got %0b want 0", bus.mem_we); else passes++;
    checks++; if (bus.count !== 7'd4) $display("FAIL basic_count: got %0d want 4", bus.count); else passes++;
    checks++; if (bus.checksum !== 32'd128) $display("FAIL basic_checksum: got %0d want 128", bus.checksum); else passes++;
    checks++; if (bus.overflow !== 1'b0 || bus.busy !== 1'b0) $display("FAIL basic_flags: got ovf=%0b busy=%0b want 0 0", bus.overflow, bus.busy); else passes++;
    checks++; if (obs_q.size() != exp_q.size()) $display("FAIL basic_nwrites: got %0d want %0d", obs_q.size(), exp_q.size()); else passes++;
  endtask

  task automatic test_gapped();
    bit pat[6] = '{1, 0, 0, 1, 0, 1};
    step(1, 3, 0, '0);
    foreach (pat[i]) begin
      step(0, 0, pat[i], rand_vec());
      checks++; if (bus.mem_we !== m_we || bus.mem_addr !== m_addr) $display("FAIL gap_write[%0d]: got we=%0b addr=%0d want we=%0b addr=%0d", i, bus.mem_we, bus.mem_addr, m_we, m_addr); else passes++;
      checks++; if (bus.mem_din !== m_din) $display("FAIL gap_din[%0d]: got %0h want %0h", i, bus.mem_din[31:0], m_din[31:0]); else passes++;
      checks++; if (bus.done !== m_done) $display("FAIL gap_done[%0d]: got %0b want %0b", i, bus.done, m_done); else passes++;
    end
    checks++; if (bus.checksum !== m_sum) $display("FAIL gap_checksum: got %0h want %0h", bus.checksum, m_sum); else passes++;
  endtask

  task automatic test_overflow();
    exp_q.delete(); obs_q.delete();
    step(1, 2, 0, '0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, rand_vec());
    step(0, 0, 0, '0);
    for (int i = 0; i < 2; i++) step(0, 0, 1, rand_vec());
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    checks++; if (obs_q.size() != 2) $display("FAIL ovf_nwrites: got %0d want 2", obs_q.size()); else passes++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL ovf_write[%0d]: got addr=%0d want addr=%0d", i, obs_q[i][ADDR_W+DATA_W-1 -: ADDR_W], exp_q[i][ADDR_W+DATA_W-1 -: ADDR_W]); else passes++;
    end
    checks++; if (bus.overflow !== 1'b1) $display("FAIL ovf_sticky: got %0b want 1", bus.overflow); else passes++;
    checks++; if (bus.count !== 7'd2) $display("FAIL ovf_count: got %0d want 2", bus.count); else passes++;
    checks++; if (bus.checksum !== m_sum) $display("FAIL ovf_checksum: got %0h want %0h", bus.checksum, m_sum); else passes++;
    checks++; if (bus.done !== 1'b1) $display("FAIL ovf_done: got %0b want 1", bus.done); else passes++;
  endtask

  task automatic test_depth();
    int nvs[2] = '{0, 100};
    foreach (nvs[n]) begin
      exp_q.delete(); obs_q.delete();
      step(1, nvs[n], 0, '0);
      for (int i = 0; i < 70; i++) step(0, 0, 1, rand_vec());
      checks++; if (obs_q.size() != DEPTH) $display("FAIL depth_nwrites[%0d]: got %0d want %0d", nvs[n], obs_q.size(), DEPTH); else passes++;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL depth_write[%0d]: got addr=%0d want addr=%0d", i, obs_q[i][ADDR_W+DATA_W-1 -: ADDR_W], i); else passes++;
      end
      checks++; if (bus.count !== 7'd64) $display("FAIL depth_count[%0d]: got %0d want 64", nvs[n], bus.count); else passes++;
      checks++; if (bus.mem_addr !== 6'd63) $display("FAIL depth_last_addr[%0d]: got %0d want 63", nvs[n], bus.mem_addr); else passes++;
      checks++; if (bus.checksum !== m_sum) $display("FAIL depth_checksum[%0d]: got %0h want %0h", nvs[n], bus.checksum, m_sum); else passes++;
      checks++; if (bus.done !== 1'b1 || bus.overflow !== 1'b1) $display("FAIL depth_flags[%0d]: got done=%0b ovf=%0b want 1 1", nvs[n], bus.done, bus.overflow); else passes++;
    end
  endtask

  task automatic test_restart();
    logic [DATA_W-1:0] d;
    step(1, 1, 0, '0);
    step(0, 0, 1, rand_vec());
    step(0, 0, 1, rand_vec());
    step(1, 10, 1, rand_vec());
    checks++; if (bus.overflow !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b1) $display("FAIL rearm_from_done: got ovf=%0b done=%0b busy=%0b want 0 0 1", bus.overflow, bus.done, bus.busy); else passes++;
    for (int i = 0; i < 5; i++) step(0, 0, 1, rand_vec());
    step(1, 10, 1, rand_vec());
    checks++; if (bus.count !== '0 || bus.checksum !== '0) $display("FAIL restart_clear: got count=%0d sum=%0h want 0 0", bus.count, bus.checksum); else passes++;
    checks++; if (bus.mem_we !== 1'b0 || bus.overflow !== 1'b0) $display("FAIL restart_drop: got we=%0b ovf=%0b want 0 0", bus.mem_we, bus.overflow); else passes++;
    d = rand_vec();
    step(0, 0, 1, d);
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== '0 || bus.mem_din !== d) $display("FAIL restart_first: got we=%0b addr=%0d want we=1 addr=0", bus.mem_we, bus.mem_addr); else passes++;
    checks++; if (bus.count !== 7'd1 || bus.checksum !== lane_total(d)) $display("FAIL restart_sum: got count=%0d sum=%0h want 1 %0h", bus.count, bus.checksum, lane_total(d)); else passes++;
  endtask

  task automatic test_async_reset();
    step(1, 8, 0, '0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, rand_vec());
    bus.valid_out = 1; bus.data_out = rand_vec();
    @(posedge clk);
    #2 rst = 1;
    #1;
    checks++; if (bus.mem_we !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL arst_ctrl: got we=%0b busy=%0b done=%0b want 0 0 0", bus.mem_we, bus.busy, bus.done); else passes++;
    checks++; if (bus.count !== '0 || bus.checksum !== '0 || bus.overflow !== 1'b0) $display("FAIL arst_stats: got count=%0d sum=%0h ovf=%0b want 0 0 0", bus.count, bus.checksum, bus.overflow); else passes++;
    checks++; if (bus.mem_addr !== '0 || bus.mem_din !== '0) $display("FAIL arst_bus: got addr=%0d din nonzero want 0", bus.mem_addr); else passes++;
    @(negedge clk); #1;
    rst = 0;
    model_reset();
    obs_q.delete();
    for (int i = 0; i < 4; i++) step(0, 0, 1, rand_vec());
    checks++; if (obs_q.size() != 0 || bus.count !== '0) $display("FAIL idle_ignore: got writes=%0d count=%0d want 0 0", obs_q.size(), bus.count); else passes++;
    step(1, 2, 1, rand_vec());
    step(0, 0, 1, rand_vec());
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== '0) $display("FAIL arst_rearm: got we=%0b addr=%0d want 1 0", bus.mem_we, bus.mem_addr); else passes++;
  endtask

  task automatic test_random();
    step(1, $urandom_range(0, 80), 0, '0);
    for (int i = 0; i < 400; i++) begin
      bit s;
      int nv;
      s  = ($urandom_range(0, 39) == 0);
      nv = $urandom_range(0, 80);
      step(s, nv, ($urandom_range(0, 9) < 7), rand_vec());
      checks++; if (bus.mem_we !== m_we) $display("FAIL rnd_we[%0d]: got %0b want %0b", i, bus.mem_we, m_we); else passes++;
      if (m_we) begin
        checks++; if (bus.mem_addr !== m_addr || bus.mem_din !== m_din) $display("FAIL rnd_write[%0d]: got addr=%0d want %0d", i, bus.mem_addr, m_addr); else passes++;
      end
      checks++; if (bus.busy !== m_collect || bus.done !== m_done) $display("FAIL rnd_state[%0d]: got busy=%0b done=%0b want %0b %0b", i, bus.busy, bus.done, m_collect, m_done); else passes++;
      checks++; if (bus.count !== (ADDR_W+1)'(m_count)) $display("FAIL rnd_count[%0d]: got %0d want %0d", i, bus.count, m_count); else passes++;
      checks++; if (bus.checksum !== m_sum) $display("FAIL rnd_checksum[%0d]: got %0h want %0h", i, bus.checksum, m_sum); else passes++;
      checks++; if (bus.overflow !== m_ovf) $display("FAIL rnd_overflow[%0d]: got %0b want %0b", i, bus.overflow, m_ovf); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_overflow();
    test_depth();
    test_restart();
    test_async_reset();
    test_random();
    idle_inputs();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/result_capture.md
Name: result_capture

Overview:
- Sink end of the accelerator's streaming vector interface: accepts valid-qualified wide result vectors from the datapath and writes them into an external result BRAM (write port) at consecutive addresses.
- The capture is bounded: a start pulse arms it for a programmed number of vectors; it then reports done, the count, a running lane-sum checksum and a sticky overflow flag for late or extra beats.
- Sits after the datapath output, mirroring the BRAM-fed stimulus sequencer at the input.

Parameters:
- DATA_W, 1024: vector width in bits; must be a multiple of 32.
- ADDR_W, 6: result BRAM address width.
- DEPTH, 64: maximum number of vectors per run; must be ≤ 2^ADDR_W.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset: asynchronous, active-high.
- start  in  1  single-cycle arm/re-arm pulse.
- num_vec  in  ADDR_W+1  vectors expected; sampled only on start.
- valid_out  in  1  datapath result valid; one beat per cycle when high, no backpressure.
- data_out  in  DATA_W  result vector; qualified by valid_out.
- mem_we  out  1  BRAM write enable.
- mem_addr  out  ADDR_W  BRAM write address.
- mem_din  out  DATA_W  BRAM write data.
- busy  out  1  high in COLLECT.
- done  out  1  high in DONE.
- count  out  ADDR_W+1  vectors written this run.
- checksum  out  32  running sum mod 2^32 of all 32-bit lanes of every captured vector.
- overflow  out  1  sticky; a beat arrived in DONE.

Behaviour:
- Reset (async, rst=1): state=IDLE; mem_we, mem_addr, mem_din, busy, done, count, checksum and overflow all 0; target=0.
- target rule on start:
  - num_vec=0 → target=DEPTH.
  - num_vec>DEPTH → target=DEPTH.
  - otherwise target=num_vec.
- States: IDLE, COLLECT, DONE. busy and done are registered decodes of the state.
- IDLE:
  - valid_out beats are ignored; no write, no flag change.
  - start → COLLECT at the next edge; count, checksum, overflow and done clear; target latched.
  - A beat coincident with start is ignored.
- COLLECT, on each edge with valid_out=1:
  - mem_we←1, mem_addr←count[ADDR_W-1:0], mem_din←data_out.
  - count←count+1.
  - checksum←checksum + Σ data_out[32k+31:32k] for k = 0..DATA_W/32−1, mod 2^32.
  - Latency: one cycle from sampled beat to registered write.
- COLLECT, on an edge with valid_out=0: mem_we←0; mem_addr and mem_din hold.
- COLLECT → DONE: at the same edge that captures the beat for which count+1==target; done rises together with that beat's mem_we. Back-to-back beats must be captured without gaps.
- DONE:
  - mem_we←0 at the next edge; no further writes.
  - Any valid_out beat sets overflow (sticky); count and checksum unchanged.
- start priority:
  - start in COLLECT or DONE aborts/re-arms as from IDLE, including clearing flags. A coincident beat is dropped and does not set overflow.
  - Priority order: rst > start > valid_out.
- Address never wraps: count ≤ target ≤ DEPTH ≤ 2^ADDR_W.
- Async reset mid-run returns to IDLE immediately; any partially written BRAM contents are left as-is.

Test Plan:
- Reset, then start with num_vec=4, then 4 consecutive beats with data lanes all 32'h1 → mem_we high for 4 cycles at addr 0..3; done=1 on the 4th write cycle; count=4; checksum=4×32=128; overflow=0.
- num_vec=3 with beats gapped (valid 1,0,0,1,0,1) → writes at addr 0,1,2 only in the cycle after each beat; mem_addr/mem_din hold between writes; done after the 3rd beat.
- num_vec=2, then 3 beats, then 2 more beats after done → exactly 2 writes; overflow=1 and stays 1; count=2; checksum unchanged by extra beats.
- num_vec=0 and num_vec=100 (DEPTH=64) → each run captures exactly 64 beats; last write at addr 63; count=64; no wrap to addr 0.
- start mid-run after 5 of 10 beats, coincident with a valid beat → coincident beat dropped; count=0, checksum=0, overflow=0; next beat is written at addr 0.
- Async rst asserted between clock edges during COLLECT → all outputs 0 immediately; valid beats while in IDLE produce no writes until the next start.
